// File: rtl/cnf_loader_if.sv
// Literal-stream handshake between a CNF source and cnf_loader.
// The master drives literal beats and the slave (loader) returns lit_ready.
interface cnf_loader_if #(
    parameter int N = 6
);
    localparam int VW = $clog2(N);

    logic          lit_valid;
    logic          lit_ready;
    logic [VW-1:0] lit_var;
    logic          lit_neg;
    logic          lit_eoc;
    logic          lit_eof;

    modport master (
        output lit_valid, lit_var, lit_neg, lit_eoc, lit_eof,
        input  lit_ready
    );

    modport slave (
        input  lit_valid, lit_var, lit_neg, lit_eoc, lit_eof,
        output lit_ready
    );
endinterface

// File: rtl/cnf_loader.sv
// cnf_loader: turns a CNF literal stream into flattened positive/negated clause masks for the
// Schoening solver core. Optional macro CNF_LOADER_DEDUP_EN: repeated literals don't count toward K.
module cnf_loader #(
    parameter int N = 6,
    parameter int M = 5,
    parameter int K = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    cnf_loader_if.slave              lit,
    output logic [N*M-1:0]           array_orig,
    output logic [N*M-1:0]           array_inv,
    output logic [$clog2(M+1)-1:0]   clause_count,
    output logic                     formula_valid,
    output logic                     solver_reset,
    output logic                     err,
    output logic [1:0]               err_code
);
    localparam int CW = $clog2(M+1);
    localparam int VW = $clog2(N);
    localparam int LW = $clog2(K+1);
    localparam logic [CW-1:0] M_C   = CW'(M);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [LW-1:0] K_C   = LW'(K);
    localparam logic [LW-1:0] LONE  = LW'(1);
    localparam logic [VW:0]   N_C   = (VW+1)'(N);

    typedef enum logic [2:0] {IDLE, LOAD, FILL, READY, ERROR} state_e;

    state_e                 state_q, state_d;
    logic [M-1:0][N-1:0]    orig_q, orig_d;
    logic [M-1:0][N-1:0]    inv_q, inv_d;
    logic [CW-1:0]          ci_q, ci_d;
    logic [LW-1:0]          li_q, li_d;
    logic [CW-1:0]          clause_count_q, clause_count_d;
    logic                   formula_valid_q, formula_valid_d;
    logic                   solver_reset_q, solver_reset_d;
    logic                   err_q, err_d;
    logic [1:0]             err_code_q, err_code_d;
    logic                   accept;
    logic                   dup;
    logic [1:0]             beat_err;

    assign lit.lit_ready = (state_q == IDLE) || (state_q == LOAD);
    assign accept        = lit.lit_valid && lit.lit_ready;

    always_comb begin
        state_d         = state_q;
        orig_d          = orig_q;
        inv_d           = inv_q;
        ci_d            = ci_q;
        li_d            = li_q;
        clause_count_d  = clause_count_q;
        formula_valid_d = formula_valid_q;
        solver_reset_d  = solver_reset_q;
        err_d           = err_q;
        err_code_d      = err_code_q;
        dup             = 1'b0;
        beat_err        = 2'b00;

        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    // Slot/variable checks come first so the mask lookups below stay in range.
                    if ({1'b0, lit.lit_var} >= N_C) begin
                        beat_err = 2'b11;
                    end else if (ci_q == M_C) begin
                        beat_err = 2'b10;
                    end else begin
`ifdef CNF_LOADER_DEDUP_EN
                        dup = lit.lit_neg ? inv_q[ci_q][lit.lit_var] : orig_q[ci_q][lit.lit_var];
`else
                        dup = 1'b0;
`endif
                        if (!dup && li_q == K_C) begin
                            beat_err = 2'b01;
                        end
                    end

                    if (beat_err != 2'b00) begin
                        state_d    = ERROR;
                        err_d      = 1'b1;
                        err_code_d = beat_err;
                    end else begin
                        state_d = LOAD;
                        if (lit.lit_neg) begin
                            inv_d[ci_q][lit.lit_var] = 1'b1;
                        end else begin
                            orig_d[ci_q][lit.lit_var] = 1'b1;
                        end
                        if (!dup) begin
                            li_d = li_q + LONE;
                        end
                        if (lit.lit_eoc || lit.lit_eof) begin
                            ci_d           = ci_q + ONE_C;
                            li_d           = '0;
                            clause_count_d = ci_q + ONE_C;
                        end
                        if (lit.lit_eof) begin
                            if (ci_q + ONE_C == M_C) begin
                                state_d         = READY;
                                formula_valid_d = 1'b1;
                                solver_reset_d  = 1'b0;
                            end else begin
                                state_d = FILL;
                            end
                        end
                    end
                end
            end
            FILL: begin
                // Padding slots hold x0 | ~x0, which is always true.
                orig_d[ci_q][0] = 1'b1;
                inv_d[ci_q][0]  = 1'b1;
                ci_d            = ci_q + ONE_C;
                if (ci_q + ONE_C == M_C) begin
                    state_d         = READY;
                    formula_valid_d = 1'b1;
                    solver_reset_d  = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            orig_q          <= '0;
            inv_q           <= '0;
            ci_q            <= '0;
            li_q            <= '0;
            clause_count_q  <= '0;
            formula_valid_q <= 1'b0;
            solver_reset_q  <= 1'b1;
            err_q           <= 1'b0;
            err_code_q      <= 2'b00;
        end else begin
            state_q         <= state_d;
            orig_q          <= orig_d;
            inv_q           <= inv_d;
            ci_q            <= ci_d;
            li_q            <= li_d;
            clause_count_q  <= clause_count_d;
            formula_valid_q <= formula_valid_d;
            solver_reset_q  <= solver_reset_d;
            err_q           <= err_d;
            err_code_q      <= err_code_d;
        end
    end

    assign array_orig    = orig_q;
    assign array_inv     = inv_q;
    assign clause_count  = clause_count_q;
    assign formula_valid = formula_valid_q;
    assign solver_reset  = solver_reset_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
endmodule

// File: tb/tb_cnf_loader.sv
// Testbench for cnf_loader (N=6, M=5, K=3): table of literal-stream vectors with expected masks,
// checked through a scoreboard queue, plus hand-written reset/hold sequences.
module tb_cnf_loader;
    localparam int N = 6;
    localparam int M = 5;
    localparam int K = 3;
    localparam int NV = 7;

    typedef struct packed {
        logic [3:0]        nbeats;
        logic [11:0][5:0]  beats;   // each beat {eof, eoc, neg, var[2:0]}
        logic [29:0]       orig;
        logic [29:0]       inv;
        logic [2:0]        cc;
        logic              err;
        logic [1:0]        code;
        logic [3:0]        lat;     // edges from eof/error beat to formula_valid/err
    } vec_t;

    logic        clk;
    logic        reset;
    logic [29:0] array_orig;
    logic [29:0] array_inv;
    logic [2:0]  clause_count;
    logic        formula_valid;
    logic        solver_reset;
    logic        err;
    logic [1:0]  err_code;

    cnf_loader_if #(.N(N)) lif ();

    cnf_loader #(.N(N), .M(M), .K(K)) dut (
        .clk          (clk),
        .reset        (reset),
        .lit          (lif.slave),
        .array_orig   (array_orig),
        .array_inv    (array_inv),
        .clause_count (clause_count),
        .formula_valid(formula_valid),
        .solver_reset (solver_reset),
        .err          (err),
        .err_code     (err_code)
    );

    vec_t vecs [NV];
    vec_t exp_q[$];
    int   tests;
    int   fails;
    int   lat_seen;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] bt(int v, bit n, bit c, bit f);
        logic [2:0] vv;
        vv = 3'(v);
        return {f, c | f, n, vv};
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic drive_idle();
        lif.lit_valid = 1'b0;
        lif.lit_var   = '0;
        lif.lit_neg   = 1'b0;
        lif.lit_eoc   = 1'b0;
        lif.lit_eof   = 1'b0;
    endtask

    task automatic reset_dut();
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drive_beat(input logic [5:0] b);
        lif.lit_valid = 1'b1;
        lif.lit_var   = b[2:0];
        lif.lit_neg   = b[3];
        lif.lit_eoc   = b[4];
        lif.lit_eof   = b[5];
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    // Drives every beat of a vector (stopping once err is up), then counts edges to completion.
    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < int'(v.nbeats); i++) begin
            if (err) break;
            drive_beat(v.beats[i]);
        end
        lat_seen = 0;
        while (!formula_valid && !err && lat_seen < 20) begin
            @(posedge clk);
            #1;
            lat_seen++;
        end
    endtask

    task automatic checkOutput(input int vi);
        vec_t e;
        string p;
        p = $sformatf("v%0d", vi);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s scoreboard: got empty queue expected entry", p);
            return;
        end
        e = exp_q.pop_front();
        cmp({p, " orig"},       32'(array_orig),    32'(e.orig));
        cmp({p, " inv"},        32'(array_inv),     32'(e.inv));
        cmp({p, " count"},      32'(clause_count),  32'(e.cc));
        cmp({p, " err"},        32'(err),           32'(e.err));
        cmp({p, " err_code"},   32'(err_code),      32'(e.code));
        cmp({p, " valid"},      32'(formula_valid), 32'(!e.err));
        cmp({p, " solver_rst"}, 32'(solver_reset),  32'(e.err));
        cmp({p, " latency"},    32'(lat_seen),      32'(e.lat));
        cmp({p, " lit_ready"},  32'(lif.lit_ready), 32'd0);
    endtask

    task automatic run_vector(input int vi);
        reset_dut();
        exp_q.push_back(vecs[vi]);
        applyStimulus(vecs[vi]);
        checkOutput(vi);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        drive_idle();
        for (int i = 0; i < NV; i++) vecs[i] = '0;

        // Five clauses, no padding needed
        vecs[0].nbeats = 10;
        vecs[0].beats[0] = bt(0, 0, 0, 0);
        vecs[0].beats[1] = bt(2, 1, 1, 0);
        vecs[0].beats[2] = bt(1, 0, 0, 0);
        vecs[0].beats[3] = bt(2, 0, 1, 0);
        vecs[0].beats[4] = bt(2, 1, 0, 0);
        vecs[0].beats[5] = bt(5, 1, 1, 0);
        vecs[0].beats[6] = bt(3, 0, 0, 0);
        vecs[0].beats[7] = bt(4, 0, 0, 0);
        vecs[0].beats[8] = bt(5, 0, 1, 0);
        vecs[0].beats[9] = bt(5, 0, 1, 1);
        vecs[0].orig = 30'b100000_111000_000000_000110_000001;
        vecs[0].inv  = 30'b000000_000000_100100_000000_000100;
        vecs[0].cc   = 3'd5;

        // Two clauses, three padded slots
        vecs[1].nbeats = 2;
        vecs[1].beats[0] = bt(0, 0, 1, 0);
        vecs[1].beats[1] = bt(1, 1, 1, 1);
        vecs[1].orig = 30'b000001_000001_000001_000000_000001;
        vecs[1].inv  = 30'b000001_000001_000001_000010_000000;
        vecs[1].cc   = 3'd2;
        vecs[1].lat  = 4'd3;

        // Fourth literal in one clause
        vecs[2].nbeats = 4;
        for (int i = 0; i < 4; i++) vecs[2].beats[i] = bt(i, 0, 0, 0);
        vecs[2].orig = 30'b000111;
        vecs[2].err  = 1'b1;
        vecs[2].code = 2'b01;

        // Sixth clause overflows M
        vecs[3].nbeats = 6;
        for (int i = 0; i < 6; i++) vecs[3].beats[i] = bt(0, 0, 1, 0);
        vecs[3].orig = 30'b000001_000001_000001_000001_000001;
        vecs[3].cc   = 3'd5;
        vecs[3].err  = 1'b1;
        vecs[3].code = 2'b10;

        // Variable index out of range
        vecs[4].nbeats = 1;
        vecs[4].beats[0] = bt(6, 0, 0, 0);
        vecs[4].err  = 1'b1;
        vecs[4].code = 2'b11;

        // Repeated literal
        vecs[5].nbeats = 4;
        vecs[5].beats[0] = bt(1, 0, 0, 0);
        vecs[5].beats[1] = bt(1, 0, 0, 0);
        vecs[5].beats[2] = bt(1, 0, 0, 0);
        vecs[5].beats[3] = bt(2, 0, 1, 1);
`ifdef CNF_LOADER_DEDUP_EN
        vecs[5].orig = 30'b000001_000001_000001_000001_000110;
        vecs[5].inv  = 30'b000001_000001_000001_000001_000000;
        vecs[5].cc   = 3'd1;
        vecs[5].lat  = 4'd4;
`else
        vecs[5].orig = 30'b000010;
        vecs[5].err  = 1'b1;
        vecs[5].code = 2'b01;
`endif

        // Error on an eof beat takes precedence over completion
        vecs[6].nbeats = 4;
        for (int i = 0; i < 3; i++) vecs[6].beats[i] = bt(i, 0, 0, 0);
        vecs[6].beats[3] = bt(3, 0, 1, 1);
        vecs[6].orig = 30'b000111;
        vecs[6].err  = 1'b1;
        vecs[6].code = 2'b01;

        reset_dut();
        cmp("rst orig",       32'(array_orig),    32'd0);
        cmp("rst inv",        32'(array_inv),     32'd0);
        cmp("rst count",      32'(clause_count),  32'd0);
        cmp("rst valid",      32'(formula_valid), 32'd0);
        cmp("rst solver_rst", 32'(solver_reset),  32'd1);
        cmp("rst err",        32'(err),           32'd0);
        cmp("rst err_code",   32'(err_code),      32'd0);
        cmp("rst lit_ready",  32'(lif.lit_ready), 32'd1);

        for (int i = 0; i < NV; i++) run_vector(i);

        // READY ignores further beats
        run_vector(0);
        drive_beat(bt(1, 1, 1, 0));
        cmp("ready hold orig",  32'(array_orig),    32'(vecs[0].orig));
        cmp("ready hold inv",   32'(array_inv),     32'(vecs[0].inv));
        cmp("ready hold valid", 32'(formula_valid), 32'd1);

        // Partial load, idle gap, then reset mid-LOAD and reload
        reset_dut();
        for (int i = 0; i < 3; i++) drive_beat(vecs[0].beats[i]);
        repeat (3) @(posedge clk);
        #1;
        cmp("partial orig",      32'(array_orig),    32'h81);
        cmp("partial inv",       32'(array_inv),     32'h4);
        cmp("partial count",     32'(clause_count),  32'd1);
        cmp("partial lit_ready", 32'(lif.lit_ready), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cmp("midrst orig",       32'(array_orig),    32'd0);
        cmp("midrst inv",        32'(array_inv),     32'd0);
        cmp("midrst count",      32'(clause_count),  32'd0);
        cmp("midrst solver_rst", 32'(solver_reset),  32'd1);
        cmp("midrst lit_ready",  32'(lif.lit_ready), 32'd1);
        exp_q.push_back(vecs[0]);
        applyStimulus(vecs[0]);
        checkOutput(0);

        // Reset during FILL clears padding in progress
        reset_dut();
        drive_beat(vecs[1].beats[0]);
        drive_beat(vecs[1].beats[1]);
        cmp("fill lit_ready", 32'(lif.lit_ready), 32'd0);
        cmp("fill valid",     32'(formula_valid), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cmp("fillrst orig",   32'(array_orig),    32'd0);
        cmp("fillrst inv",    32'(array_inv),     32'd0);
        repeat (4) @(posedge clk);
        #1;
        cmp("fillrst idle valid", 32'(formula_valid), 32'd0);
        cmp("fillrst idle orig",  32'(array_orig),    32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
